// File: rtl/key_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | key_debounce                                                               |
// | Synchronises an active-low push-button, rejects contact bounce, and emits  |
// | a clean level, one-cycle press/release strobes and a running press count.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module key_debounce #(
  parameter int CNT_WIDTH       = 20,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_n,
  output logic       key_level,
  output logic       key_press,
  output logic       key_release,
  output logic [7:0] press_cnt
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] c_cnt_last = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 r_s0;
  logic                 r_s1;
  state_t               r_state;
  state_t               w_state_next;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_next;
  logic                 w_accept_press;
  logic                 w_accept_release;
  logic                 r_key_level;
  logic                 r_key_press;
  logic                 r_key_release;
  logic [7:0]           r_press_cnt;

  // Resetting to 1 means a key held through reset is seen as a fresh press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s0 <= 1'b1;
      r_s1 <= 1'b1;
    end else begin
      r_s0 <= key_n;
      r_s1 <= r_s0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_accept_press   = 1'b0;
    w_accept_release = 1'b0;
    case (r_state)
      IDLE: begin
        if (!r_s1) begin
          w_state_next = PRESS_WAIT;
          w_cnt_next   = '0;
        end
      end
      PRESS_WAIT: begin
        if (r_s1) begin
          w_state_next = IDLE;
        end else if (r_cnt == c_cnt_last) begin
          w_state_next   = PRESSED;
          w_accept_press = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (r_s1) begin
          w_state_next = RELEASE_WAIT;
          w_cnt_next   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (!r_s1) begin
          w_state_next = PRESSED;
        end else if (r_cnt == c_cnt_last) begin
          w_state_next     = IDLE;
          w_accept_release = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_level   <= 1'b0;
      r_key_press   <= 1'b0;
      r_key_release <= 1'b0;
      r_press_cnt   <= 8'd0;
    end else begin
      r_key_press   <= w_accept_press;
      r_key_release <= w_accept_release;
      if (w_accept_press) begin
        r_key_level <= 1'b1;
        r_press_cnt <= r_press_cnt + 8'd1;
      end else if (w_accept_release) begin
        r_key_level <= 1'b0;
      end
    end
  end

  assign key_level   = r_key_level;
  assign key_press   = r_key_press;
  assign key_release = r_key_release;
  assign press_cnt   = r_press_cnt;

endmodule
`default_nettype wire

// File: tb/tb_key_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_key_debounce                                                            |
// | Directed self-checking bench for key_debounce with N=4, CNT_WIDTH=3.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_key_debounce;

  localparam int CNT_WIDTH       = 3;
  localparam int DEBOUNCE_CYCLES = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_n = 1'b1;
  logic       key_level;
  logic       key_press;
  logic       key_release;
  logic [7:0] press_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int press_pulses   = 0;
  int release_pulses = 0;

  key_debounce #(
    .CNT_WIDTH       (CNT_WIDTH),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_n       (key_n),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release),
    .press_cnt   (press_cnt)
  );

  always #5 clk = ~clk;

  // Strobes are one cycle wide, so one sample per cycle counts each pulse once.
  always @(negedge clk) begin
    if (key_press)   press_pulses++;
    if (key_release) release_pulses++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [10:0] exp;
    rst_n = 1'b0;
    key_n = 1'b1;
    #2;
    exp = 11'd0;
    n_checks++;
    if ({key_level, key_press, key_release, press_cnt} !== exp) begin
      n_fail++;
      $display("FAIL reset_async: got %b want %b", {key_level, key_press, key_release, press_cnt}, exp);
    end
    tick; tick;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      n_checks++;
      if ({key_level, key_press, key_release, press_cnt} !== exp) begin
        n_fail++;
        $display("FAIL reset_idle[%0d]: got %b want %b", i, {key_level, key_press, key_release, press_cnt}, exp);
      end
    end
  endtask

  task automatic test_bounce;
    // Samples: low 3, high 1, low 2, then high.
    logic [11:0] pattern = 12'b1111_1100_1000;
    logic [10:0] exp;
    int p0 = press_pulses;
    for (int i = 0; i < 12; i++) begin
      key_n = pattern[i];
      tick;
      exp = 11'd0;
      n_checks++;
      if ({key_level, key_press, key_release, press_cnt} !== exp) begin
        n_fail++;
        $display("FAIL bounce[%0d]: got %b want %b", i, {key_level, key_press, key_release, press_cnt}, exp);
      end
    end
    n_checks++;
    if (press_pulses - p0 !== 0) begin
      n_fail++;
      $display("FAIL bounce_pulses: got %0d want 0", press_pulses - p0);
    end
  endtask

  task automatic test_clean_press;
    logic [10:0] exp;
    key_n = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick;
      exp = {(i >= 6) ? 1'b1 : 1'b0, (i == 6) ? 1'b1 : 1'b0, 1'b0, (i >= 6) ? 8'd1 : 8'd0};
      n_checks++;
      if ({key_level, key_press, key_release, press_cnt} !== exp) begin
        n_fail++;
        $display("FAIL clean_press[E%0d]: got %b want %b", i, {key_level, key_press, key_release, press_cnt}, exp);
      end
    end
  endtask

  task automatic test_release_bounce;
    // Samples: high 2, low 1, then high; final rise is sample 3, release at 3+6.
    logic [11:0] pattern = 12'b1111_1111_1011;
    logic [10:0] exp;
    for (int i = 0; i < 12; i++) begin
      key_n = pattern[i];
      tick;
      exp = {(i < 9) ? 1'b1 : 1'b0, 1'b0, (i == 9) ? 1'b1 : 1'b0, 8'd1};
      n_checks++;
      if ({key_level, key_press, key_release, press_cnt} !== exp) begin
        n_fail++;
        $display("FAIL release_bounce[E%0d]: got %b want %b", i, {key_level, key_press, key_release, press_cnt}, exp);
      end
    end
  endtask

  task automatic test_wrap;
    int p0;
    int r0;
    logic [7:0] exp_cnt;
    key_n = 1'b1;
    rst_n = 1'b0;
    tick; tick;
    rst_n = 1'b1;
    tick;
    p0 = press_pulses;
    r0 = release_pulses;
    for (int k = 1; k <= 256; k++) begin
      key_n = 1'b0;
      repeat (8) tick;
      if (k >= 255) begin
        exp_cnt = (k == 255) ? 8'd255 : 8'd0;
        n_checks++;
        if (press_cnt !== exp_cnt) begin
          n_fail++;
          $display("FAIL wrap_cnt[%0d]: got %0d want %0d", k, press_cnt, exp_cnt);
        end
      end
      key_n = 1'b1;
      repeat (8) tick;
    end
    n_checks++;
    if (press_pulses - p0 !== 256) begin
      n_fail++;
      $display("FAIL wrap_press_pulses: got %0d want 256", press_pulses - p0);
    end
    n_checks++;
    if (release_pulses - r0 !== 256) begin
      n_fail++;
      $display("FAIL wrap_release_pulses: got %0d want 256", release_pulses - r0);
    end
  endtask

  task automatic test_reset_mid_wait;
    logic [10:0] exp;
    key_n = 1'b0;
    repeat (8) tick;
    key_n = 1'b1;
    repeat (8) tick;
    n_checks++;
    if (press_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL mid_wait_precount: got %0d want 1", press_cnt);
    end
    // Entered PRESS_WAIT at E2; after E4 the counter is two cycles in.
    key_n = 1'b0;
    repeat (5) tick;
    #3;
    rst_n = 1'b0;
    #1;
    exp = 11'd0;
    n_checks++;
    if ({key_level, key_press, key_release, press_cnt} !== exp) begin
      n_fail++;
      $display("FAIL mid_wait_async: got %b want %b", {key_level, key_press, key_release, press_cnt}, exp);
    end
    key_n = 1'b1;
    tick; tick;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick;
      n_checks++;
      if ({key_level, key_press, key_release, press_cnt} !== exp) begin
        n_fail++;
        $display("FAIL mid_wait_after[%0d]: got %b want %b", i, {key_level, key_press, key_release, press_cnt}, exp);
      end
    end
  endtask

  task automatic test_held_through_reset;
    logic [10:0] exp;
    rst_n = 1'b0;
    key_n = 1'b0;
    tick; tick;
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick;
      exp = {(i >= 6) ? 1'b1 : 1'b0, (i == 6) ? 1'b1 : 1'b0, 1'b0, (i >= 6) ? 8'd1 : 8'd0};
      n_checks++;
      if ({key_level, key_press, key_release, press_cnt} !== exp) begin
        n_fail++;
        $display("FAIL held_reset[E%0d]: got %b want %b", i, {key_level, key_press, key_release, press_cnt}, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_clean_press();
    test_release_bounce();
    test_wrap();
    test_reset_mid_wait();
    test_held_through_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
